// File: rtl/aurora_axi_rx_demux.sv
// aurora_axi_rx_demux: fans the 32-bit Aurora RX stream out to ETHCOUNT per-channel FIFOs, rescaling both signed 16-bit lanes.
// Latency: 2 cycles from accepted input beat to output valid (scale stage register, then FIFO write).
// Backpressure: axis_s_tready drops while any unmasked FIFO holds more than FIFO_DEPTH-2 entries; the spare slot absorbs the staged beat.
// Optional feature: define AURORA_RX_DEMUX_SAT_EN for clamping and sat_cnt; otherwise lanes wrap and sat_cnt is 0.
module aurora_axi_rx_demux #(
  parameter int ETHCOUNT   = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int SIM        = 0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [1:0]            sel,
  input  logic [ETHCOUNT-1:0]   eth_mask,
  output logic                  axis_s_tready,
  input  logic [31:0]           axis_s_tdata,
  input  logic [3:0]            axis_s_tkeep,
  input  logic                  axis_s_tvalid,
  input  logic                  axis_s_tlast,
  input  logic [ETHCOUNT-1:0]   axis_m_tready,
  output logic [ETHCOUNT*32-1:0] axis_m_tdata,
  output logic [ETHCOUNT*4-1:0] axis_m_tkeep,
  output logic [ETHCOUNT-1:0]   axis_m_tvalid,
  output logic [ETHCOUNT-1:0]   axis_m_tlast,
  output logic                  frame_active,
  output logic [15:0]           sat_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic {IDLE, FRAME} state_t;

  state_t              state_q, state_d;
  logic [ETHCOUNT-1:0] act_mask_q, act_mask_d;
  logic [1:0]          act_sel_q, act_sel_d;
  logic [ETHCOUNT-1:0] m;
  logic [1:0]          s_eff;
  logic [1:0]          sh;
  logic [ETHCOUNT-1:0] credit_ok;
  logic                accept;
  logic [17:0]         lane_w;
  logic [31:0]         scaled;

  logic                stg_vld_q;
  logic [31:0]         stg_dat_q;
  logic                stg_last_q;
  logic [ETHCOUNT-1:0] stg_wmask_q;

  logic                unused_tkeep;
  assign unused_tkeep = ^axis_s_tkeep;

  // Inside a frame the latched configuration rules; between frames the live inputs do.
  assign m      = (state_q == FRAME) ? act_mask_q : eth_mask;
  assign s_eff  = (state_q == FRAME) ? act_sel_q  : sel;
  assign sh     = (s_eff == 2'd3) ? 2'd0 : s_eff;
  assign axis_s_tready = &credit_ok;
  assign accept = axis_s_tvalid & axis_s_tready;
  assign frame_active = (state_q == FRAME);

  // State and frame-boundary configuration registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      act_mask_q <= '0;
      act_sel_q  <= 2'd0;
    end else begin
      state_q    <= state_d;
      act_mask_q <= act_mask_d;
      act_sel_q  <= act_sel_d;
    end
  end

  // Next state: latch mask/sel on the first beat of a frame, leave FRAME on tlast.
  always_comb begin
    state_d    = state_q;
    act_mask_d = act_mask_q;
    act_sel_d  = act_sel_q;
    if (accept) begin
      case (state_q)
        IDLE: begin
          act_mask_d = eth_mask;
          act_sel_d  = sel;
          if (!axis_s_tlast) state_d = FRAME;
        end
        FRAME: begin
          if (axis_s_tlast) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef AURORA_RX_DEMUX_SAT_EN
  logic        any_sat;
  logic [15:0] sat_cnt_q;

  // Per-lane 18-bit shift, clamped to the signed 16-bit range.
  always_comb begin
    lane_w  = '0;
    scaled  = '0;
    any_sat = 1'b0;
    for (int l = 0; l < 2; l++) begin
      lane_w = {{2{axis_s_tdata[l*16+15]}}, axis_s_tdata[l*16 +: 16]} << sh;
      if (lane_w[17:15] != 3'b000 && lane_w[17:15] != 3'b111) begin
        any_sat = 1'b1;
        scaled[l*16 +: 16] = lane_w[17] ? 16'h8000 : 16'h7FFF;
      end else begin
        scaled[l*16 +: 16] = lane_w[15:0];
      end
    end
  end

  // Saturation event counter, sticky at all-ones.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                               sat_cnt_q <= 16'd0;
    else if (accept && any_sat && sat_cnt_q != 16'hFFFF) sat_cnt_q <= sat_cnt_q + 16'd1;
  end
  assign sat_cnt = sat_cnt_q;
`else
  logic [1:0] unused_hi;

  // Per-lane shift; the low 16 bits are kept (two's-complement wrap).
  always_comb begin
    lane_w    = '0;
    scaled    = '0;
    unused_hi = '0;
    for (int l = 0; l < 2; l++) begin
      lane_w = {{2{axis_s_tdata[l*16+15]}}, axis_s_tdata[l*16 +: 16]} << sh;
      scaled[l*16 +: 16] = lane_w[15:0];
      unused_hi = unused_hi ^ lane_w[17:16];
    end
  end
  assign sat_cnt = 16'd0;
`endif

  // Scale stage: carries the beat plus the set of channels it must be written to.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stg_vld_q   <= 1'b0;
      stg_dat_q   <= '0;
      stg_last_q  <= 1'b0;
      stg_wmask_q <= '0;
    end else begin
      stg_vld_q <= accept;
      if (accept) begin
        stg_dat_q   <= scaled;
        stg_last_q  <= axis_s_tlast;
        stg_wmask_q <= ~m;
      end
    end
  end

  for (genvar x = 0; x < ETHCOUNT; x++) begin : g_ch
    logic [32:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   cnt_q;
    logic          push, pop, vld;

    assign vld  = (cnt_q != '0);
    assign push = stg_vld_q & stg_wmask_q[x];
    assign pop  = vld & axis_m_tready[x];
    assign credit_ok[x] = (32'(cnt_q) <= FIFO_DEPTH - 2) | m[x];

    // FIFO storage; contents need no reset because valid gates the outputs.
    always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= {stg_last_q, stg_dat_q};
    end

    // Pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        wptr_q <= '0;
        rptr_q <= '0;
        cnt_q  <= '0;
      end else begin
        if (push) wptr_q <= wptr_q + 1'b1;
        if (pop)  rptr_q <= rptr_q + 1'b1;
        case ({push, pop})
          2'b10:   cnt_q <= cnt_q + 1'b1;
          2'b01:   cnt_q <= cnt_q - 1'b1;
          default: cnt_q <= cnt_q;
        endcase
      end
    end

    assign axis_m_tvalid[x]         = vld;
    assign axis_m_tdata[x*32 +: 32] = vld ? mem_q[rptr_q][31:0] : 32'd0;
    assign axis_m_tlast[x]          = vld & mem_q[rptr_q][32];
    assign axis_m_tkeep[x*4 +: 4]   = vld ? 4'hF : 4'h0;

    if (SIM != 0) begin : g_sim_chk
      a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
        !(push && 32'(cnt_q) == FIFO_DEPTH))
        else $error("channel %0d FIFO written while full", x);
    end
  end

endmodule

// File: tb/tb_aurora_axi_rx_demux.sv
// Bench for aurora_axi_rx_demux: directed scenarios plus randomized frames, checked by a scoreboard.
// Expected beats come from an arithmetic reference model and are compared per channel by a monitor.
module tb_aurora_axi_rx_demux;
  localparam int E = 4;

  logic            clk, rstn;
  logic [1:0]      sel;
  logic [E-1:0]    eth_mask;
  logic            axis_s_tready;
  logic [31:0]     axis_s_tdata;
  logic [3:0]      axis_s_tkeep;
  logic            axis_s_tvalid, axis_s_tlast;
  logic [E-1:0]    axis_m_tready;
  logic [E*32-1:0] axis_m_tdata;
  logic [E*4-1:0]  axis_m_tkeep;
  logic [E-1:0]    axis_m_tvalid, axis_m_tlast;
  logic            frame_active;
  logic [15:0]     sat_cnt;

  aurora_axi_rx_demux #(.ETHCOUNT(E), .FIFO_DEPTH(4), .SIM(1)) dut (
    .clk(clk), .rstn(rstn), .sel(sel), .eth_mask(eth_mask),
    .axis_s_tready(axis_s_tready), .axis_s_tdata(axis_s_tdata), .axis_s_tkeep(axis_s_tkeep),
    .axis_s_tvalid(axis_s_tvalid), .axis_s_tlast(axis_s_tlast),
    .axis_m_tready(axis_m_tready), .axis_m_tdata(axis_m_tdata), .axis_m_tkeep(axis_m_tkeep),
    .axis_m_tvalid(axis_m_tvalid), .axis_m_tlast(axis_m_tlast),
    .frame_active(frame_active), .sat_cnt(sat_cnt)
  );

  typedef struct packed { logic [31:0] dat; logic last; } exp_t;
  exp_t exp_q [E][$];

  int checks = 0;
  int errors = 0;
  int m_sat = 0;
  bit m_in_frame = 0;
  logic [E-1:0] m_mask = '0;
  int m_sh = 0;
  bit saw_stall = 0;
  bit rnd_rdy = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Reference lane scaling: multiply by 2^shift in plain integer arithmetic.
  function automatic logic [15:0] mdl_lane(input logic [15:0] x, input int s, output bit sat);
    int v;
    v = int'($signed(x)) * (1 << s);
    sat = (v > 32767) || (v < -32768);
`ifdef AURORA_RX_DEMUX_SAT_EN
    if (v > 32767)  return 16'h7FFF;
    if (v < -32768) return 16'h8000;
`endif
    return 16'(v);
  endfunction

  // Model of one accepted input beat.
  task automatic model_accept(input logic [31:0] d, input logic l);
    exp_t e;
    bit sa, sb;
    if (!m_in_frame) begin
      m_mask = eth_mask;
      m_sh   = (sel == 2'd3) ? 0 : int'(sel);
    end
    e.dat  = {mdl_lane(d[31:16], m_sh, sb), mdl_lane(d[15:0], m_sh, sa)};
    e.last = l;
`ifdef AURORA_RX_DEMUX_SAT_EN
    if ((sa || sb) && m_sat < 65535) m_sat++;
`endif
    for (int x = 0; x < E; x++)
      if (!m_mask[x]) exp_q[x].push_back(e);
    m_in_frame = !l;
  endtask

  function automatic int qtotal();
    int t = 0;
    for (int x = 0; x < E; x++) t += exp_q[x].size();
    return t;
  endfunction

  // Monitor: every handshake observed on an output channel pops and compares.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rstn) begin
        for (int x = 0; x < E; x++) begin
          if (axis_m_tvalid[x] && axis_m_tready[x]) begin
            chk($sformatf("ch%0d tkeep", x), 32'(axis_m_tkeep[x*4 +: 4]), 32'hF);
            if (exp_q[x].size() == 0) begin
              chk($sformatf("ch%0d unexpected beat", x), axis_m_tdata[x*32 +: 32], 32'hDEAD_BEEF);
            end else begin
              e = exp_q[x].pop_front();
              chk($sformatf("ch%0d data", x), axis_m_tdata[x*32 +: 32], e.dat);
              chk($sformatf("ch%0d tlast", x), 32'(axis_m_tlast[x]), 32'(e.last));
            end
          end
        end
      end
    end
  end

  // Random consumer readiness while enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_rdy) axis_m_tready = 4'($urandom_range(0, 15));
    end
  end

  // Drives one beat starting just after a rising edge; returns just after the edge that took it.
  task automatic drive_beat(input logic [31:0] d, input logic l);
    int n = 0;
    axis_s_tvalid = 1'b1;
    axis_s_tdata  = d;
    axis_s_tlast  = l;
    forever begin
      @(negedge clk);
      chk("frame_active", 32'(frame_active), 32'(m_in_frame));
      if (axis_s_tready) begin
        model_accept(d, l);
        break;
      end
      saw_stall = 1'b1;
      n++;
      if (n >= 300) begin
        fail("s_tready");
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    axis_s_tvalid = 1'b0;
    axis_s_tlast  = 1'b0;
  endtask

  task automatic send_frame(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) drive_beat(base + 32'(i * 32'h0001_0001), i == n - 1);
    idle();
    chk("frame_active after tlast", 32'(frame_active), 32'd0);
  endtask

  task automatic drain();
    int n = 0;
    while (qtotal() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    chk("scoreboard drained", 32'(qtotal()), 32'd0);
    chk("sat_cnt", {16'd0, sat_cnt}, 32'(m_sat));
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0;
    sel = 2'd0;
    eth_mask = '0;
    axis_s_tdata = '0;
    axis_s_tkeep = 4'hF;
    axis_s_tvalid = 1'b0;
    axis_s_tlast = 1'b0;
    axis_m_tready = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    chk("reset tvalid", 32'(axis_m_tvalid), 32'd0);
    chk("reset tkeep", 32'(axis_m_tkeep), 32'd0);
    chk("reset tready", 32'(axis_s_tready), 32'd1);
    chk("reset frame_active", 32'(frame_active), 32'd0);
    chk("reset sat_cnt", {16'd0, sat_cnt}, 32'd0);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // T1: two-cycle latency, then a 4-beat frame.
    drive_beat(32'h0001_FFFF, 1'b1);
    idle();
    @(negedge clk);
    chk("T1 valid at N+1", 32'(axis_m_tvalid), 32'd0);
    @(negedge clk);
    chk("T1 valid at N+2", 32'(axis_m_tvalid), 32'hF);
    @(posedge clk);
    #1;
    send_frame(4, 32'h0001_FFFF);
    drain();

    // T2 and T3: scaling boundaries.
    sel = 2'd2;
    drive_beat(32'h4000_C000, 1'b1);
    idle();
    drain();
    sel = 2'd1;
    drive_beat(32'h1234_FFFE, 1'b1);
    idle();
    drain();
    sel = 2'd3;
    drive_beat(32'h8000_7FFF, 1'b1);
    idle();
    drain();

    // T4: one stuck consumer stalls the stream, then releases.
    sel = 2'd0;
    saw_stall = 1'b0;
    axis_m_tready = 4'b1011;
    fork
      send_frame(10, 32'h0100_0200);
      begin
        repeat (30) @(posedge clk);
        #1;
        axis_m_tready = 4'hF;
      end
    join
    chk("T4 stall seen", 32'(saw_stall), 32'd1);
    drain();

    // T5: mask change mid-frame applies from the next frame.
    eth_mask = 4'b0000;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) eth_mask = 4'b0100;
      drive_beat(32'h0A00_0B00 + 32'(i), i == 5);
    end
    idle();
    send_frame(4, 32'h0C00_0D00);
    drain();

    // Randomized frames with random readiness, masks and scale selects.
    rnd_rdy = 1'b1;
    for (int f = 0; f < 30; f++) begin
      int len;
      len = $urandom_range(1, 6);
      sel = 2'($urandom_range(0, 3));
      eth_mask = 4'($urandom_range(0, 15));
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          eth_mask = 4'($urandom_range(0, 15));
          sel = 2'($urandom_range(0, 3));
        end
        drive_beat($urandom, i == len - 1);
        if ($urandom_range(0, 2) == 0) begin
          idle();
          @(posedge clk);
          #1;
        end
      end
      idle();
    end
    rnd_rdy = 1'b0;
    @(posedge clk);
    #1;
    axis_m_tready = 4'hF;
    drain();

    // T6: mid-frame reset with FIFOs partly full.
    sel = 2'd0;
    eth_mask = '0;
    axis_m_tready = 4'h0;
    for (int i = 0; i < 3; i++) drive_beat(32'h5555_0000 + 32'(i), 1'b0);
    idle();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    chk("T6 tvalid", 32'(axis_m_tvalid), 32'd0);
    chk("T6 tready", 32'(axis_s_tready), 32'd1);
    chk("T6 frame_active", 32'(frame_active), 32'd0);
    for (int x = 0; x < E; x++) exp_q[x].delete();
    m_in_frame = 1'b0;
    m_sat = 0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    axis_m_tready = 4'hF;
    send_frame(3, 32'h7000_0001);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
